// File: rtl/mips_trace_buffer.sv
// Instruction-trace capture for the single-cycle MIPS core.
// Circular PC/instr buffer frozen around a trigger PC, drained oldest-first.
module mips_trace_buffer #(
    parameter int ADDR_W    = 32,
    parameter int INSTR_W   = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                         clk,
    input  logic                         PcReSet,
    input  logic [ADDR_W-1:0]            pc_in,
    input  logic [INSTR_W-1:0]           instr_in,
    input  logic                         valid_in,
    input  logic                         trig_en,
    input  logic [ADDR_W-1:0]            trig_pc,
    input  logic                         arm,
    input  logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_pc,
    output logic [INSTR_W-1:0]           rd_instr,
    output logic                         rd_valid,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         triggered
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t cur, nxt;

    logic [ADDR_W+INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt;
    logic [CW-1:0] post_cnt, count_nxt;
    logic          do_write, hit, post_last, pop, enter_done;

    assign state = cur;

    always_comb begin
        do_write   = (cur == ARMED || cur == POST) && valid_in && !arm;
        hit        = do_write && cur == ARMED && trig_en && pc_in == trig_pc;
        post_last  = do_write && cur == POST &&
                     (post_cnt + 1'b1 == CW'(POST_TRIG));
        pop        = cur == DONE && rd_en && count != '0 && !arm;
        wr_ptr_nxt = do_write ? wr_ptr + 1'b1 : wr_ptr;
        count_nxt  = (do_write && count != CW'(DEPTH)) ? count + 1'b1 : count;
        nxt        = cur;
        unique case (1'b1)
            arm:       nxt = ARMED;
            hit:       nxt = (POST_TRIG == 0) ? DONE : POST;
            post_last: nxt = DONE;
            default:   nxt = cur;
        endcase
        enter_done = nxt == DONE && cur != DONE;
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {pc_in, instr_in};
    end

    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            cur       <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            count     <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_pc     <= '0;
            rd_instr  <= '0;
        end else begin
            cur      <= nxt;
            rd_valid <= pop;
            if (arm) begin
                wr_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr_nxt;
                count  <= pop ? count - 1'b1 : count_nxt;
                if (hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= '0;
                end else if (do_write && cur == POST) begin
                    post_cnt <= post_cnt + 1'b1;
                end
                // full buffer truncates count to 0, so oldest == wr_ptr
                if (enter_done) rd_ptr <= wr_ptr_nxt - count_nxt[PW-1:0];
                else if (pop)   rd_ptr <= rd_ptr + 1'b1;
                if (pop) {rd_pc, rd_instr} <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: table of capture scenarios
// plus hand sequences for reset, underflow and arm priority.
module tb_mips_trace_buffer;

    localparam int DEPTH = 16;
    localparam int POST  = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          PcReSet = 1'b0;
    logic [31:0]   pc_in = '0;
    logic [31:0]   instr_in = '0;
    logic          valid_in = 1'b0;
    logic          trig_en = 1'b0;
    logic [31:0]   trig_pc = '0;
    logic          arm = 1'b0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_pc;
    logic [31:0]   rd_instr;
    logic          rd_valid;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          triggered;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] tp;
        logic        en;
        int          ns;
        bit          gaps;
        logic [1:0]  exp_state;
        int          exp_count;
        logic        exp_trig;
        int          first_n;
    } vec_t;

    vec_t vecs[4];

    mips_trace_buffer #(
        .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .POST_TRIG(POST)
    ) dut (
        .clk(clk), .PcReSet(PcReSet), .pc_in(pc_in), .instr_in(instr_in),
        .valid_in(valid_in), .trig_en(trig_en), .trig_pc(trig_pc),
        .arm(arm), .rd_en(rd_en), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_valid(rd_valid), .state(state), .count(count),
        .triggered(triggered)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc_of(input int n);
        return 32'h0040_0000 + 32'(4 * n);
    endfunction

    function automatic logic [31:0] ins_of(input int n);
        return 32'h8C00_0000 | 32'(n);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arm with a valid matching sample alongside: must not be captured
    task automatic do_arm(input logic [31:0] tp, input logic en);
        trig_pc  = tp;
        trig_en  = en;
        arm      = 1'b1;
        valid_in = 1'b1;
        pc_in    = tp;
        instr_in = 32'hFFFF_FFFF;
        tick();
        arm      = 1'b0;
        valid_in = 1'b0;
        check("arm_state", 32'(state), 32'd1);
        check("arm_count", 32'(count), 32'd0);
        check("arm_trig", 32'(triggered), 32'd0);
    endtask

    task automatic feed(input int ns, input logic [31:0] tp,
                        input logic en, input bit gaps);
        int tn;
        tn = int'((tp - 32'h0040_0000) >> 2);
        for (int n = 0; n < ns; n++) begin
            if (gaps && en && n > tn) begin
                valid_in = 1'b0;
                pc_in    = 32'h0090_0000 + 32'(4 * n);
                instr_in = 32'hDEAD_0000 | 32'(n);
                tick();
            end
            valid_in = 1'b1;
            pc_in    = pc_of(n);
            instr_in = ins_of(n);
            tick();
            if (en && n == tn + POST - 1)
                check("post_window", 32'(state), 32'd2);
            if (en && n == tn + POST)
                check("done_entry", 32'(state), 32'd3);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0040_0080, 1'b1, 51, 1'b0, 2'd3, 16, 1'b1, 25};
        vecs[1] = '{32'h0040_0008, 1'b1, 20, 1'b0, 2'd3, 11, 1'b1, 0};
        vecs[2] = '{32'h0040_0008, 1'b1, 20, 1'b1, 2'd3, 11, 1'b1, 0};
        vecs[3] = '{32'h0040_0080, 1'b0, 40, 1'b0, 2'd1, 16, 1'b0, 0};

        #1 PcReSet = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_pc", rd_pc, 32'd0);
        @(negedge clk);
        @(negedge clk);
        PcReSet = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            do_arm(vecs[v].tp, vecs[v].en);
            feed(vecs[v].ns, vecs[v].tp, vecs[v].en, vecs[v].gaps);
            check($sformatf("v%0d_state", v), 32'(state),
                  32'(vecs[v].exp_state));
            check($sformatf("v%0d_count", v), 32'(count),
                  32'(vecs[v].exp_count));
            check($sformatf("v%0d_trig", v), 32'(triggered),
                  32'(vecs[v].exp_trig));
            rd_en = 1'b1;
            if (vecs[v].exp_state == 2'd3) begin
                for (int k = 0; k < vecs[v].exp_count; k++) begin
                    tick();
                    check($sformatf("v%0d_pop%0d_valid", v, k),
                          32'(rd_valid), 32'd1);
                    check($sformatf("v%0d_pop%0d_pc", v, k), rd_pc,
                          pc_of(vecs[v].first_n + k));
                    check($sformatf("v%0d_pop%0d_instr", v, k), rd_instr,
                          ins_of(vecs[v].first_n + k));
                end
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check($sformatf("v%0d_under_valid", v), 32'(rd_valid),
                          32'd0);
                    check($sformatf("v%0d_under_pc", v), rd_pc,
                          pc_of(vecs[v].first_n + vecs[v].exp_count - 1));
                    check($sformatf("v%0d_under_count", v), 32'(count),
                          32'd0);
                end
            end else begin
                tick();
                check($sformatf("v%0d_rd_ignored", v), 32'(rd_valid), 32'd0);
                check($sformatf("v%0d_count_held", v), 32'(count),
                      32'(vecs[v].exp_count));
            end
            rd_en = 1'b0;
        end

        do_arm(pc_of(0), 1'b1);
        feed(9, pc_of(0), 1'b1, 1'b0);
        check("prio_pre_state", 32'(state), 32'd3);
        check("prio_pre_count", 32'(count), 32'd9);
        arm   = 1'b1;
        rd_en = 1'b1;
        tick();
        arm   = 1'b0;
        rd_en = 1'b0;
        check("prio_state", 32'(state), 32'd1);
        check("prio_count", 32'(count), 32'd0);
        check("prio_rd_valid", 32'(rd_valid), 32'd0);
        check("prio_trig", 32'(triggered), 32'd0);

        feed(4, pc_of(0), 1'b1, 1'b0);
        check("post_state", 32'(state), 32'd2);
        check("post_trig", 32'(triggered), 32'd1);
        #2 PcReSet = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_trig", 32'(triggered), 32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_rd_pc", rd_pc, 32'd0);
        @(negedge clk);
        PcReSet = 1'b0;
        valid_in = 1'b1;
        pc_in    = pc_of(0);
        tick();
        valid_in = 1'b0;
        check("idle_no_capture_state", 32'(state), 32'd0);
        check("idle_no_capture_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
